y_ins_loader: RTL and testbench



---
 rtl/y_ins_loader.sv | 145 ++++++++++++++
 tb/tb_y_ins_loader.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/y_ins_loader.sv
// RV32I program loader: encodes R/I/S/B/U/J field sets into instruction words and streams them into memory.
// Optional immediate range checking is enabled by defining Y_LOADER_IMM_CHECK_EN.
module y_ins_loader #(
  parameter logic [31:0] BASE  = 32'h0,
  parameter int unsigned DEPTH = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  input  logic        last,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic        mem_write,
  output logic [15:0] count,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wd_q, mem_wd_d;
  logic        mem_write_q, mem_write_d;
  logic [15:0] count_q, count_d;
  logic        last_q, last_d;
  logic        err_q, err_d;

  logic [31:0] enc_word;
  logic        fmt_bad;
  logic        imm_bad;
  logic        full;

  always_comb begin
    enc_word = 32'h0000_0013;
    fmt_bad  = 1'b0;
    case (fmt)
      3'd0: enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
      3'd1: enc_word = {imm[11:0], rs1, funct3, rd, opcode};
      3'd2: enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      3'd3: enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      3'd4: enc_word = {imm[31:12], rd, opcode};
      3'd5: enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: begin
        enc_word = 32'h0000_0013;
        fmt_bad  = 1'b1;
      end
    endcase
  end

  always_comb begin
    imm_bad = 1'b0;
`ifdef Y_LOADER_IMM_CHECK_EN
    case (fmt)
      3'd1, 3'd2: imm_bad = ($signed(imm) < -2048) || ($signed(imm) > 2047);
      3'd3:       imm_bad = ($signed(imm) < -4096) || ($signed(imm) > 4094) || imm[0];
      3'd4:       imm_bad = (imm[11:0] != 12'h000);
      3'd5:       imm_bad = ($signed(imm) < -1048576) || ($signed(imm) > 1048574) || imm[0];
      default:    imm_bad = 1'b0;
    endcase
`endif
  end

  assign full = (count_q == 16'(DEPTH));

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wd_d    = mem_wd_q;
    mem_write_d = 1'b0;
    count_d     = count_q;
    last_d      = last_q;
    err_d       = err_q;
    in_ready    = 1'b0;
    done        = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (full) begin
            // Memory exhausted: drop the word but still honour the end-of-program marker.
            err_d = 1'b1;
            if (last) state_d = DONE;
          end else begin
            mem_write_d = 1'b1;
            mem_wd_d    = enc_word;
            last_d      = last;
            err_d       = err_q | fmt_bad | imm_bad;
            state_d     = WRITE;
          end
        end
      end
      WRITE: begin
        // Address tracks the count so it always points at the next free word.
        count_d    = count_q + 16'd1;
        mem_addr_d = BASE + {14'b0, count_d, 2'b00};
        state_d    = last_q ? DONE : IDLE;
      end
      DONE: begin
        done = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_addr_q  <= BASE;
      mem_wd_q    <= '0;
      mem_write_q <= 1'b0;
      count_q     <= '0;
      last_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wd_q    <= mem_wd_d;
      mem_write_q <= mem_write_d;
      count_q     <= count_d;
      last_q      <= last_d;
      err_q       <= err_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wd    = mem_wd_q;
  assign mem_write = mem_write_q;
  assign count     = count_q;
  assign err       = err_q;

endmodule

// File: tb/tb_y_ins_loader.sv
// Directed bench for y_ins_loader: a cycle-level behavioural model checked every cycle plus literal expectations.
module tb_y_ins_loader;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;
  logic        last;
  logic [31:0] mem_addr, mem_wd;
  logic        mem_write;
  logic [15:0] count;
  logic        done, err;

  int checks = 0;
  int errors = 0;
  bit checking = 0;

  always #5 clk = ~clk;

  y_ins_loader #(.BASE(BASE), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .last(last),
    .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_write(mem_write),
    .count(count), .done(done), .err(err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Field placement expressed as shifted bit ranges of the immediate.
  function automatic logic [31:0] fld(input logic [31:0] v, input int hi, input int lo);
    return (v >> lo) & ((32'h1 << (hi - lo + 1)) - 32'h1);
  endfunction

  function automatic logic [31:0] model_word(input logic [2:0] f, input logic [6:0] op,
      input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
      input logic [4:0] s2, input logic [31:0] im);
    logic [31:0] base_bits;
    base_bits = 32'(op) | (32'(f3) << 12) | (32'(s1) << 15);
    case (f)
      3'd0: return base_bits | (32'(d) << 7) | (32'(s2) << 20) | (32'(f7) << 25);
      3'd1: return base_bits | (32'(d) << 7) | (fld(im, 11, 0) << 20);
      3'd2: return base_bits | (32'(s2) << 20) | (fld(im, 4, 0) << 7) | (fld(im, 11, 5) << 25);
      3'd3: return base_bits | (32'(s2) << 20) | (fld(im, 11, 11) << 7) | (fld(im, 4, 1) << 8)
                   | (fld(im, 10, 5) << 25) | (fld(im, 12, 12) << 31);
      3'd4: return 32'(op) | (32'(d) << 7) | (im & 32'hFFFF_F000);
      3'd5: return 32'(op) | (32'(d) << 7) | (fld(im, 19, 12) << 12) | (fld(im, 11, 11) << 20)
                   | (fld(im, 10, 1) << 21) | (fld(im, 20, 20) << 31);
      default: return 32'h0000_0013;
    endcase
  endfunction

`ifdef Y_LOADER_IMM_CHECK_EN
  function automatic bit range_bad(input logic [2:0] f, input logic [31:0] im);
    int s;
    s = int'(im);
    case (f)
      3'd1, 3'd2: return (s < -2048) || (s > 2047);
      3'd3:       return (s < -4096) || (s > 4094) || (s % 2 != 0);
      3'd4:       return (im % 4096) != 0;
      3'd5:       return (s < -1048576) || (s > 1048574) || (s % 2 != 0);
      default:    return 1'b0;
    endcase
  endfunction
`endif

  logic [31:0] m_word;
  logic        m_bad;
  always_comb begin
    m_word = model_word(fmt, opcode, funct3, funct7, rd, rs1, rs2, imm);
    m_bad  = (fmt > 3'd5);
`ifdef Y_LOADER_IMM_CHECK_EN
    m_bad  = m_bad | range_bad(fmt, imm);
`endif
  end

  int          m_count;
  logic        m_err, m_done, m_wr, m_lastp;
  logic [31:0] m_addr, m_wd;

  always @(posedge clk) begin
    if (reset) begin
      m_count <= 0; m_err <= 1'b0; m_done <= 1'b0; m_wr <= 1'b0;
      m_lastp <= 1'b0; m_addr <= BASE; m_wd <= '0;
    end else if (m_wr) begin
      m_wr    <= 1'b0;
      m_count <= m_count + 1;
      m_addr  <= m_addr + 32'd4;
      if (m_lastp) m_done <= 1'b1;
    end else if (!m_done && in_valid) begin
      if (m_count == DEPTH) begin
        m_err <= 1'b1;
        if (last) m_done <= 1'b1;
      end else begin
        m_wr    <= 1'b1;
        m_wd    <= m_word;
        m_lastp <= last;
        if (m_bad) m_err <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("cyc_in_ready", 32'(in_ready), 32'(!m_wr && !m_done));
      chk("cyc_mem_write", 32'(mem_write), 32'(m_wr));
      chk("cyc_mem_addr", mem_addr, m_addr);
      chk("cyc_mem_wd", mem_wd, m_wd);
      chk("cyc_count", 32'(count), 32'(m_count));
      chk("cyc_done", 32'(done), 32'(m_done));
      chk("cyc_err", 32'(err), 32'(m_err));
    end
  end

  // Waits for in_ready, presents one field set, returns #1 after the accept edge.
  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
      input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
      input logic [31:0] im, input logic lst);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready stayed %b, required 1", in_ready);
    end
    fmt = f; opcode = op; funct3 = f3; funct7 = f7; rd = d; rs1 = s1; rs2 = s2;
    imm = im; last = lst; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; fmt = '0; opcode = '0; funct3 = '0; funct7 = '0;
    rd = '0; rs1 = '0; rs2 = '0; imm = '0; last = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    checking = 1'b1;

    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_addr", mem_addr, BASE);
    chk("rst_mem_wd", mem_wd, 32'h0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_done_err", {30'b0, done, err}, 32'd0);

    send(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
    chk("i_write", 32'(mem_write), 32'd1);
    chk("i_word", mem_wd, 32'h0050_0093);
    chk("i_addr", mem_addr, BASE);
    send(3'd2, 7'b0100011, 3'b010, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0);
    chk("s_word", mem_wd, 32'h0020_A423);
    chk("s_addr", mem_addr, BASE + 32'd4);
    @(posedge clk); #1;
    chk("s_count", 32'(count), 32'd2);
    chk("s_write_off", 32'(mem_write), 32'd0);

    do_reset();
    send(3'd3, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC, 1'b0);
    chk("b_word", mem_wd, 32'hFE00_0EE3);
    chk("b_addr", mem_addr, BASE);
    send(3'd5, 7'b1101111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b1);
    chk("j_word", mem_wd, 32'h0010_00EF);
    chk("j_addr", mem_addr, BASE + 32'd4);
    @(posedge clk); #1;
    chk("j_done", 32'(done), 32'd1);
    chk("j_in_ready", 32'(in_ready), 32'd0);

    do_reset();
    send(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd1, 1'b0);
    send(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'd2, 1'b0);
    chk("full_2nd_addr", mem_addr, BASE + 32'd4);
    send(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd4, 5'd0, 5'd0, 32'd3, 1'b1);
    chk("full_no_write", 32'(mem_write), 32'd0);
    chk("full_err", 32'(err), 32'd1);
    chk("full_done", 32'(done), 32'd1);
    chk("full_count", 32'(count), 32'd2);
    chk("full_addr", mem_addr, BASE + 32'd8);

    do_reset();
    send(3'd7, 7'b0110011, 3'd1, 7'd5, 5'd6, 5'd7, 5'd8, 32'd9, 1'b0);
    chk("bad_fmt_word", mem_wd, 32'h0000_0013);
    chk("bad_fmt_err", 32'(err), 32'd1);

    do_reset();
    send(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd4096, 1'b0);
    chk("imm4096_word", mem_wd, 32'h0000_0093);
`ifdef Y_LOADER_IMM_CHECK_EN
    chk("imm4096_err", 32'(err), 32'd1);
`else
    chk("imm4096_err", 32'(err), 32'd0);
`endif

    do_reset();
    send(3'd0, 7'b0110011, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
    chk("r_word", mem_wd, 32'h4020_81B3);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rstw_no_write", 32'(mem_write), 32'd0);
    chk("rstw_count", 32'(count), 32'd0);
    chk("rstw_addr", mem_addr, BASE);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rstw_in_ready", 32'(in_ready), 32'd1);

    fmt = 3'd1; opcode = 7'b0010011; funct3 = 3'd0; rd = 5'd5; rs1 = 5'd0;
    imm = 32'd7; last = 1'b0; in_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1 in_valid = 1'b0;
    chk("hold_count", 32'(count), 32'd2);
    chk("hold_addr", mem_addr, BASE + 32'd8);

    repeat (2) @(posedge clk);
    #1;
    checking = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
